issue_unit: RTL and testbench

Single-issue arbiter between the reservation-station queues (integer, load/store, multiply, divide) and the execution units of the Tomasulo core. It returns a same-cycle `*_issue` grant to the queue whose `issueque_ready` wins arbitration. It reserves the common data bus (CDB) slot in which that instruction's result will appear. It publishes the CDB owner for each cycle to the CDB mux.

---
 rtl/issue_unit.sv | 132 +++++++++++++
 tb/tb_issue_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_unit.sv
// Single-issue arbiter: grants one reservation-station queue per cycle and books its CDB slot.
// Define ISSUE_DIV_EN to build the divide path; otherwise div is tied off and the slot array is MUL_LAT deep.
module issue_unit #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 7
) (
  input  logic       clock,
  input  logic       nreset,
  input  logic       int_ready,
  input  logic       ls_ready,
  input  logic       mul_ready,
  input  logic       div_ready,
  input  logic       flush_valid,
  output logic       int_issue,
  output logic       ls_issue,
  output logic       mul_issue,
  output logic       div_issue,
  output logic       div_busy,
  output logic       cdb_owner_val,
  output logic [1:0] cdb_owner
);

`ifdef ISSUE_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int D = DIV_EN ? DIV_LAT : MUL_LAT;

  logic [D-1:0]      own_val;
  logic [D-1:0][1:0] own_unit;
  logic              last_ls;
  logic              slot1_free;
  logic              mul_slot_free;
  logic              div_eligible;

  assign slot1_free = !own_val[1];

  // Slot D lies past the end of the array and is therefore always free.
  generate
    if (MUL_LAT < D) begin : g_mul_slot
      assign mul_slot_free = !own_val[MUL_LAT];
    end else begin : g_mul_slot_top
      assign mul_slot_free = 1'b1;
    end
  endgenerate

`ifdef ISSUE_DIV_EN
  logic [3:0] div_cnt;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      div_cnt <= 4'd0;
    end else if (flush_valid) begin
      div_cnt <= 4'd0;
    end else if (div_issue) begin
      div_cnt <= 4'(DIV_LAT - 1);
    end else if (div_cnt != 4'd0) begin
      div_cnt <= div_cnt - 4'd1;
    end
  end

  assign div_busy     = (div_cnt != 4'd0);
  assign div_eligible = div_ready && !div_busy;
`else
  logic unused_div;
  assign unused_div   = div_ready;
  assign div_busy     = 1'b0;
  assign div_eligible = 1'b0;
`endif

  always_comb begin
    int_issue = 1'b0;
    ls_issue  = 1'b0;
    mul_issue = 1'b0;
    div_issue = 1'b0;
    if (nreset && !flush_valid) begin
      if (div_eligible) begin
        div_issue = 1'b1;
      end else if (mul_ready && mul_slot_free) begin
        mul_issue = 1'b1;
      end else if (slot1_free) begin
        if (int_ready && ls_ready) begin
          if (last_ls) int_issue = 1'b1;
          else         ls_issue  = 1'b1;
        end else if (ls_ready) begin
          ls_issue = 1'b1;
        end else if (int_ready) begin
          int_issue = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      own_val  <= '0;
      own_unit <= '0;
      last_ls  <= 1'b0;
    end else if (flush_valid) begin
      own_val  <= '0;
      own_unit <= '0;
    end else begin
      own_val  <= {1'b0, own_val[D-1:1]};
      own_unit <= {2'b00, own_unit[D-1:1]};
      if (int_issue) begin
        own_val[0]  <= 1'b1;
        own_unit[0] <= 2'd0;
        last_ls     <= 1'b0;
      end
      if (ls_issue) begin
        own_val[0]  <= 1'b1;
        own_unit[0] <= 2'd1;
        last_ls     <= 1'b1;
      end
      if (mul_issue) begin
        own_val[MUL_LAT-1]  <= 1'b1;
        own_unit[MUL_LAT-1] <= 2'd2;
      end
`ifdef ISSUE_DIV_EN
      if (div_issue) begin
        own_val[DIV_LAT-1]  <= 1'b1;
        own_unit[DIV_LAT-1] <= 2'd3;
      end
`endif
    end
  end

  assign cdb_owner_val = own_val[0];
  assign cdb_owner     = own_unit[0];

endmodule

// File: tb/tb_issue_unit.sv
// Self-checking bench for issue_unit: a due-cycle scoreboard predicts grants, CDB owner and divider occupancy.
module tb_issue_unit;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 7;
`ifdef ISSUE_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       nreset;
  logic       int_ready, ls_ready, mul_ready, div_ready, flush_valid;
  logic       int_issue, ls_issue, mul_issue, div_issue, div_busy;
  logic       cdb_owner_val;
  logic [1:0] cdb_owner;

  issue_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clock(clock), .nreset(nreset),
    .int_ready(int_ready), .ls_ready(ls_ready), .mul_ready(mul_ready), .div_ready(div_ready),
    .flush_valid(flush_valid),
    .int_issue(int_issue), .ls_issue(ls_issue), .mul_issue(mul_issue), .div_issue(div_issue),
    .div_busy(div_busy), .cdb_owner_val(cdb_owner_val), .cdb_owner(cdb_owner)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  // Scoreboard entry: the cycle a result is due on the CDB and its source unit.
  typedef struct { int due; logic [1:0] unit; } ent_t;
  ent_t sb[$];
  int   cyc;
  bit   m_last_ls;
  int   div_free_at;

  function automatic bit occ(int k);
    for (int i = 0; i < sb.size(); i++) if (sb[i].due == cyc + k) return 1'b1;
    return 1'b0;
  endfunction

  // Expected grants as {div, mul, ls, int}.
  function automatic logic [3:0] model_grant(bit ir, bit lr, bit mr, bit dr, bit fl);
    if (fl) return 4'b0000;
    if (DIV_EN && dr && cyc >= div_free_at) return 4'b1000;
    if (mr && !occ(MUL_LAT)) return 4'b0100;
    if (!occ(1)) begin
      if (ir && lr) return m_last_ls ? 4'b0001 : 4'b0010;
      if (lr) return 4'b0010;
      if (ir) return 4'b0001;
    end
    return 4'b0000;
  endfunction

  task automatic push_sorted(input int due, input logic [1:0] unit);
    ent_t e;
    int idx;
    e.due = due;
    e.unit = unit;
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].due > due) begin idx = i; break; end
    end
    sb.insert(idx, e);
  endtask

  task automatic model_reset();
    sb.delete();
    cyc = 0;
    m_last_ls = 1'b0;
    div_free_at = 0;
  endtask

  // Drive one cycle's inputs and produce the expected observable vector
  // {div,mul,ls,int, cdb_val, masked owner, div_busy}.
  task automatic drive(input bit ir, input bit lr, input bit mr, input bit dr, input bit fl,
                       output logic [3:0] eg, output logic [7:0] exp_vec);
    logic       ev;
    logic [1:0] eo;
    logic       eb;
    int_ready = ir; ls_ready = lr; mul_ready = mr; div_ready = dr; flush_valid = fl;
    eg = model_grant(ir, lr, mr, dr, fl);
    ev = 1'b0;
    eo = 2'd0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      ev = 1'b1;
      eo = sb[0].unit;
      void'(sb.pop_front());
    end
    eb = DIV_EN && (cyc < div_free_at);
    exp_vec = {eg, ev, eo, eb};
    #1;
  endtask

  task automatic commit(input logic [3:0] g, input bit fl);
    if (fl) begin
      sb.delete();
      div_free_at = 0;
    end else begin
      if (g[0]) begin push_sorted(cyc + 1, 2'd0); m_last_ls = 1'b0; end
      if (g[1]) begin push_sorted(cyc + 1, 2'd1); m_last_ls = 1'b1; end
      if (g[2]) push_sorted(cyc + MUL_LAT, 2'd2);
      if (g[3]) begin push_sorted(cyc + DIV_LAT, 2'd3); div_free_at = cyc + DIV_LAT; end
    end
    cyc++;
    @(negedge clock);
  endtask

  function automatic logic [7:0] observed();
    return {div_issue, mul_issue, ls_issue, int_issue, cdb_owner_val,
            cdb_owner_val ? cdb_owner : 2'd0, div_busy};
  endfunction

  task automatic idle(input int n);
    logic [3:0] eg;
    logic [7:0] ex;
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, eg, ex);
      commit(eg, 1'b0);
    end
  endtask

  task automatic test_reset();
    logic [7:0] ob;
    nreset = 1'b0;
    int_ready = 1; ls_ready = 1; mul_ready = 1; div_ready = 1; flush_valid = 0;
    #1;
    ob = {div_issue, mul_issue, ls_issue, int_issue, cdb_owner_val, cdb_owner, div_busy};
    checks++;
    if (ob !== 8'd0) $display("FAIL reset_hold got=%b exp=%b", ob, 8'd0);
    else passed++;
    @(negedge clock);
    int_ready = 0; ls_ready = 0; mul_ready = 0; div_ready = 0;
    nreset = 1'b1;
    #1;
    ob = {div_issue, mul_issue, ls_issue, int_issue, cdb_owner_val, cdb_owner, div_busy};
    checks++;
    if (ob !== 8'd0) $display("FAIL reset_release got=%b exp=%b", ob, 8'd0);
    else passed++;
    model_reset();
    @(negedge clock);
  endtask

  task automatic test_int_stream();
    logic [3:0] eg;
    logic [7:0] ex;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 0, 0, eg, ex);
      checks++;
      if (observed() !== ex) $display("FAIL int_stream cyc=%0d got=%b exp=%b", i, observed(), ex);
      else passed++;
      commit(eg, 1'b0);
    end
  endtask

  task automatic test_int_ls_rr();
    logic [3:0] eg;
    logic [7:0] ex;
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, 0, 0, eg, ex);
      checks++;
      if (observed() !== ex) $display("FAIL int_ls_rr cyc=%0d got=%b exp=%b", i, observed(), ex);
      else passed++;
      commit(eg, 1'b0);
    end
  endtask

  task automatic test_mul_block();
    logic [3:0] eg;
    logic [7:0] ex;
    for (int i = 0; i < 18; i++) begin
      drive(1, 0, i == 10, 0, 0, eg, ex);
      checks++;
      if (observed() !== ex) $display("FAIL mul_block t=%0d got=%b exp=%b", i, observed(), ex);
      else passed++;
      commit(eg, 1'b0);
    end
  endtask

  task automatic test_div_stream();
    logic [3:0] eg;
    logic [7:0] ex;
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 1, 0, eg, ex);
      checks++;
      if (observed() !== ex) $display("FAIL div_stream t=%0d got=%b exp=%b", i, observed(), ex);
      else passed++;
      commit(eg, 1'b0);
    end
  endtask

  task automatic test_div_mul_conflict();
    logic [3:0] eg;
    logic [7:0] ex;
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, i == 3 || i == 4, i == 0, 0, eg, ex);
      checks++;
      if (observed() !== ex) $display("FAIL div_mul_conflict t=%0d got=%b exp=%b", i, observed(), ex);
      else passed++;
      commit(eg, 1'b0);
    end
  endtask

  task automatic test_flush();
    logic [3:0] eg;
    logic [7:0] ex;
    for (int i = 0; i < 12; i++) begin
      drive(i >= 1, 0, i == 1, i == 0 || i == 3, i == 2, eg, ex);
      checks++;
      if (observed() !== ex) $display("FAIL flush t=%0d got=%b exp=%b", i, observed(), ex);
      else passed++;
      commit(eg, i == 2);
    end
  endtask

  task automatic test_random();
    logic [3:0] eg;
    logic [7:0] ex;
    bit ir, lr, mr, dr, fl;
    for (int i = 0; i < 300; i++) begin
      ir = $urandom_range(0, 1);
      lr = $urandom_range(0, 1);
      mr = ($urandom_range(0, 3) == 0);
      dr = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 15) == 0);
      drive(ir, lr, mr, dr, fl, eg, ex);
      checks++;
      if (observed() !== ex) $display("FAIL random i=%0d got=%b exp=%b", i, observed(), ex);
      else passed++;
      commit(eg, fl);
    end
  endtask

  task automatic test_reset_midstream();
    logic [3:0] eg;
    logic [7:0] ex;
    logic [7:0] ob;
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, i == 1, i == 0, 0, eg, ex);
      commit(eg, 1'b0);
    end
    nreset = 1'b0;
    #1;
    ob = {div_issue, mul_issue, ls_issue, int_issue, cdb_owner_val, cdb_owner, div_busy};
    checks++;
    if (ob !== 8'd0) $display("FAIL reset_midstream got=%b exp=%b", ob, 8'd0);
    else passed++;
    @(negedge clock);
    nreset = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, 0, 0, eg, ex);
      checks++;
      if (observed() !== ex) $display("FAIL after_reset t=%0d got=%b exp=%b", i, observed(), ex);
      else passed++;
      commit(eg, 1'b0);
    end
  endtask

  initial begin
    nreset = 1'b0;
    int_ready = 0; ls_ready = 0; mul_ready = 0; div_ready = 0; flush_valid = 0;
    model_reset();
    @(negedge clock);
    test_reset();
    test_int_stream();
    idle(DIV_LAT + 2);
    test_int_ls_rr();
    idle(DIV_LAT + 2);
    test_mul_block();
    idle(DIV_LAT + 2);
    test_div_stream();
    idle(DIV_LAT + 2);
    test_div_mul_conflict();
    idle(DIV_LAT + 2);
    test_flush();
    idle(DIV_LAT + 2);
    test_random();
    idle(DIV_LAT + 2);
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
